// File: rtl/output_port_switch.sv
// Output-port switch: locks the port to one input for the length of a wormhole
// packet and forwards flits under credit-based flow control.
module output_port_switch #(
    parameter int FLIT_WIDTH = 34,
    parameter int CREDIT_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            rr_priority_to_cs_i,
    input  logic                  rr_valid_i,
    input  logic [4:0]            flit_valid_i,
    input  logic [FLIT_WIDTH-1:0] flit_n_i,
    input  logic [FLIT_WIDTH-1:0] flit_s_i,
    input  logic [FLIT_WIDTH-1:0] flit_w_i,
    input  logic [FLIT_WIDTH-1:0] flit_e_i,
    input  logic [FLIT_WIDTH-1:0] flit_l_i,
    input  logic                  credit_i,
    output logic [4:0]            grant_o,
    output logic                  rr_change_order_o,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic                  flit_valid_o,
    output logic                  busy_o,
    output logic                  err_o
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;
    localparam logic [3:0] CREDIT_FULL = 4'(CREDIT_MAX);

    state_t                state_q, state_d;
    logic [2:0]            lock_sel_q, lock_sel_d;
    logic [3:0]            credit_q;
    logic                  err_q;
    logic [2:0]            sel;
    logic                  sel_ok, sel_present, can_send;
    logic                  granted, change, err_set, credit_err;
    logic [FLIT_WIDTH-1:0] sel_flit, fwd_flit;
    logic [1:0]            sel_type;

    assign can_send = (credit_q != 4'd0);
    assign sel      = (state_q == ACTIVE) ? lock_sel_q : rr_priority_to_cs_i;
    assign sel_ok   = (sel <= 3'd4);
    assign sel_type = sel_flit[FLIT_WIDTH-1 -: 2];

    always_comb begin
        sel_flit    = flit_l_i;
        sel_present = flit_valid_i[0];
        case (sel)
            3'd0:    begin sel_flit = flit_n_i; sel_present = flit_valid_i[4]; end
            3'd1:    begin sel_flit = flit_s_i; sel_present = flit_valid_i[3]; end
            3'd2:    begin sel_flit = flit_w_i; sel_present = flit_valid_i[2]; end
            3'd3:    begin sel_flit = flit_e_i; sel_present = flit_valid_i[1]; end
            default: begin sel_flit = flit_l_i; sel_present = flit_valid_i[0]; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        granted    = 1'b0;
        change     = 1'b0;
        err_set    = 1'b0;
        fwd_flit   = sel_flit;
        if (state_q == IDLE) begin
            if (rr_valid_i) begin
                if (!sel_ok) begin
                    err_set = 1'b1;
                end else if (sel_present && can_send) begin
                    case (sel_type)
                        TYPE_HEAD: begin
                            granted    = 1'b1;
                            lock_sel_d = sel;
                            state_d    = ACTIVE;
                        end
                        TYPE_SINGLE: begin
                            granted = 1'b1;
                            change  = 1'b1;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
        end else if (sel_present && can_send) begin
            granted = 1'b1;
            case (sel_type)
                TYPE_BODY: err_set = 1'b0;
                TYPE_TAIL: begin
                    change  = 1'b1;
                    state_d = IDLE;
                end
                // stray head/single inside a packet is passed on retyped as body
                default: begin
                    err_set                      = 1'b1;
                    fwd_flit[FLIT_WIDTH-1 -: 2] = TYPE_BODY;
                end
            endcase
        end
    end

    assign credit_err        = credit_i && !granted && (credit_q == CREDIT_FULL);
    assign grant_o           = (granted && rst_n) ? (5'b10000 >> sel) : '0;
    assign rr_change_order_o = change && rst_n;
    assign busy_o            = (state_q == ACTIVE);
    assign err_o             = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lock_sel_q   <= '0;
            credit_q     <= CREDIT_FULL;
            err_q        <= 1'b0;
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_sel_q   <= lock_sel_d;
            err_q        <= err_q | err_set | credit_err;
            flit_valid_o <= granted;
            if (granted) flit_o <= fwd_flit;
            if (granted && !credit_i)
                credit_q <= credit_q - 4'd1;
            else if (credit_i && !granted && (credit_q != CREDIT_FULL))
                credit_q <= credit_q + 4'd1;
        end
    end
endmodule

// File: tb/tb_output_port_switch.sv
// Bench for output_port_switch: directed vector table, hand-written corner
// sequences, then randomized traffic against a packet-level reference model.
module tb_output_port_switch;
    localparam int W    = 34;
    localparam int CMAX = 4;
    localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SINGLE = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   rr_sel = '0;
    logic         rr_valid = 1'b0;
    logic [4:0]   fvalid = '0;
    logic [W-1:0] fl [5];
    logic         credit = 1'b0;
    logic [4:0]   grant_o;
    logic         rr_change_order_o, flit_valid_o, busy_o, err_o;
    logic [W-1:0] flit_o;

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    output_port_switch #(.FLIT_WIDTH(W), .CREDIT_MAX(CMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .rr_priority_to_cs_i(rr_sel), .rr_valid_i(rr_valid),
        .flit_valid_i(fvalid),
        .flit_n_i(fl[0]), .flit_s_i(fl[1]), .flit_w_i(fl[2]),
        .flit_e_i(fl[3]), .flit_l_i(fl[4]),
        .credit_i(credit),
        .grant_o(grant_o), .rr_change_order_o(rr_change_order_o),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    function automatic logic [W-1:0] mk(input logic [1:0] ty, input logic [31:0] pl);
        return {ty, pl[W-3:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else npass++;
    endtask

    task automatic drive(input bit rv, input logic [2:0] s, input logic [4:0] v,
                         input logic [1:0] ty, input bit c, input int base);
        rr_valid = rv;
        rr_sel   = s;
        fvalid   = v;
        credit   = c;
        for (int p = 0; p < 5; p++) fl[p] = mk(ty, 32'(base + p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 3'd0, 5'd0, BODY, 0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rv; logic [2:0] sel; logic [4:0] fv; logic [1:0] ty; bit cr;
        logic [4:0] g; bit chg; bit busy; bit err;
    } vec_t;
    vec_t tbl [11];

    // reference model state: lock = -1 when no packet owns the port
    int           m_lock, m_cred;
    bit           m_err, m_fv;
    logic [W-1:0] m_fo;

    task automatic model_reset();
        m_lock = -1; m_cred = CMAX; m_err = 0; m_fv = 0; m_fo = '0;
    endtask

    initial begin
        static logic [4:0]   prev_g = '0;
        static logic [W-1:0] last_fo = '0;
        logic [4:0]   exp_g;
        bit           exp_chg, acc, eset;
        int           port, nlock;
        logic [1:0]   ty;
        logic [W-1:0] fwd;
        logic [1:0]   tys [8];

        for (int p = 0; p < 5; p++) fl[p] = '0;
        #12;
        @(negedge clk);
        chk("reset_grant", grant_o, 5'd0);
        chk("reset_chg", rr_change_order_o, 0);
        chk("reset_fv", flit_valid_o, 0);
        chk("reset_fo", flit_o, '0);
        chk("reset_busy", busy_o, 0);
        chk("reset_err", err_o, 0);
        tick();
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        tbl[0]  = '{0, 3'd0, 5'b00000, BODY,   0, 5'b00000, 0, 0, 0};
        tbl[1]  = '{1, 3'd4, 5'b00001, SINGLE, 1, 5'b00001, 1, 0, 0};
        tbl[2]  = '{1, 3'd0, 5'b10000, HEAD,   1, 5'b10000, 0, 0, 0};
        tbl[3]  = '{1, 3'd2, 5'b10100, BODY,   1, 5'b10000, 0, 1, 0};
        tbl[4]  = '{1, 3'd2, 5'b10100, BODY,   1, 5'b10000, 0, 1, 0};
        tbl[5]  = '{1, 3'd2, 5'b10100, TAIL,   1, 5'b10000, 1, 1, 0};
        tbl[6]  = '{1, 3'd2, 5'b00100, HEAD,   1, 5'b00100, 0, 0, 0};
        tbl[7]  = '{1, 3'd0, 5'b00100, TAIL,   1, 5'b00100, 1, 1, 0};
        tbl[8]  = '{1, 3'd1, 5'b00000, HEAD,   0, 5'b00000, 0, 0, 0};
        tbl[9]  = '{1, 3'd1, 5'b01000, BODY,   0, 5'b00000, 0, 0, 0};
        tbl[10] = '{0, 3'd0, 5'b00000, BODY,   0, 5'b00000, 0, 0, 1};
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].rv, tbl[k].sel, tbl[k].fv, tbl[k].ty, tbl[k].cr, k * 8);
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", k), grant_o, tbl[k].g);
            chk($sformatf("tbl%0d_chg", k), rr_change_order_o, tbl[k].chg);
            chk($sformatf("tbl%0d_busy", k), busy_o, tbl[k].busy);
            chk($sformatf("tbl%0d_err", k), err_o, tbl[k].err);
            chk($sformatf("tbl%0d_fv", k), flit_valid_o, prev_g != 0);
            chk($sformatf("tbl%0d_fo", k), flit_o, last_fo);
            for (int p = 0; p < 5; p++) if (tbl[k].g[4-p]) last_fo = fl[p];
            prev_g = tbl[k].g;
            tick();
        end

        // ---------------- invalid select ----------------
        do_reset();
        drive(1, 3'd6, 5'b11111, HEAD, 0, 100);
        @(negedge clk);
        chk("badsel_grant", grant_o, 5'd0);
        tick();
        drive(0, 3'd0, 5'd0, BODY, 0, 0);
        @(negedge clk);
        chk("badsel_err", err_o, 1);
        chk("badsel_fv", flit_valid_o, 0);
        tick();

        // ---------------- credit stall, five-flit packet on E ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd3, 5'b00010, (i == 0) ? HEAD : (i == 4) ? TAIL : BODY, 0, 200 + i * 8);
            @(negedge clk);
            chk($sformatf("stall_grant%0d", i), grant_o, (i < 4) ? 5'b00010 : 5'b00000);
            tick();
        end
        drive(1, 3'd3, 5'b00010, TAIL, 1, 240);
        @(negedge clk);
        chk("stall_fv", flit_valid_o, 0);
        chk("stall_fo_hold", flit_o, mk(BODY, 32'(224 + 3)));
        chk("stall_grant_credit_cycle", grant_o, 5'd0);
        tick();
        drive(1, 3'd3, 5'b00010, TAIL, 0, 248);
        @(negedge clk);
        chk("stall_resume_grant", grant_o, 5'b00010);
        chk("stall_resume_chg", rr_change_order_o, 1);
        tick();
        drive(0, 3'd0, 5'd0, BODY, 0, 0);
        @(negedge clk);
        chk("stall_fo", flit_o, mk(TAIL, 32'(248 + 3)));
        chk("stall_busy", busy_o, 0);
        chk("stall_err", err_o, 0);
        tick();

        // ---------------- simultaneous credit+grant, saturation ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'd4, 5'b00001, (i == 0) ? HEAD : BODY, i == 2, 300 + i * 8);
            @(negedge clk);
            chk($sformatf("cred_grant%0d", i), grant_o, (i < 5) ? 5'b00001 : 5'b00000);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd4, 5'b00000, BODY, 1, 0);
            @(negedge clk);
            chk($sformatf("cred_fill_err%0d", i), err_o, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd4, 5'b00001, BODY, 0, 400 + i * 8);
            @(negedge clk);
            if (i == 0) chk("cred_sat_err", err_o, 1);
            chk($sformatf("cred_sat_grant%0d", i), grant_o, (i < 4) ? 5'b00001 : 5'b00000);
            tick();
        end

        // ---------------- reset mid-packet ----------------
        do_reset();
        drive(1, 3'd1, 5'b01000, HEAD, 0, 500);
        @(negedge clk);
        chk("midrst_head_grant", grant_o, 5'b01000);
        tick();
        rst_n = 1'b0;
        drive(1, 3'd1, 5'b01000, BODY, 0, 508);
        @(negedge clk);
        chk("midrst_grant", grant_o, 5'd0);
        chk("midrst_chg", rr_change_order_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_fv", flit_valid_o, 0);
        chk("midrst_fo", flit_o, '0);
        chk("midrst_err", err_o, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 3'd3, 5'b00010, HEAD, 0, 516);
        @(negedge clk);
        chk("midrst_new_grant", grant_o, 5'b00010);
        tick();
        drive(0, 3'd0, 5'd0, BODY, 0, 0);
        @(negedge clk);
        chk("midrst_new_fo", flit_o, mk(HEAD, 32'(516 + 3)));
        chk("midrst_new_busy", busy_o, 1);
        tick();

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        model_reset();
        tys = '{BODY, BODY, BODY, HEAD, HEAD, TAIL, TAIL, SINGLE};
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 59) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rnd_rst_grant", grant_o, 5'd0);
                chk("rnd_rst_fv", flit_valid_o, 0);
                chk("rnd_rst_err", err_o, 0);
                tick();
                rst_n = 1'b1;
                model_reset();
                continue;
            end
            rr_valid = ($urandom_range(0, 3) != 0);
            rr_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            fvalid   = 5'($urandom);
            credit   = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < 5; p++) fl[p] = mk(tys[$urandom_range(0, 7)], $urandom);
            @(negedge clk);

            acc = 0; eset = 0; exp_chg = 0; nlock = m_lock;
            port = (m_lock >= 0) ? m_lock : int'(rr_sel);
            fwd = '0;
            if (m_lock < 0) begin
                if (rr_valid) begin
                    if (port > 4) eset = 1;
                    else if (fvalid[4-port] && m_cred > 0) begin
                        ty = fl[port][W-1 -: 2];
                        fwd = fl[port];
                        if (ty == HEAD) begin acc = 1; nlock = port; end
                        else if (ty == SINGLE) begin acc = 1; exp_chg = 1; end
                        else eset = 1;
                    end
                end
            end else if (fvalid[4-port] && m_cred > 0) begin
                acc = 1;
                ty = fl[port][W-1 -: 2];
                fwd = fl[port];
                if (ty == TAIL) begin exp_chg = 1; nlock = -1; end
                else if (ty != BODY) begin eset = 1; fwd = {BODY, fl[port][W-3:0]}; end
            end
            exp_g = acc ? 5'(1 << (4 - port)) : 5'd0;

            chk("rnd_grant", grant_o, exp_g);
            chk("rnd_chg", rr_change_order_o, exp_chg);
            chk("rnd_busy", busy_o, m_lock >= 0);
            chk("rnd_fv", flit_valid_o, m_fv);
            chk("rnd_fo", flit_o, m_fo);
            chk("rnd_err", err_o, m_err);

            if (acc && !credit) m_cred--;
            else if (credit && !acc) begin
                if (m_cred == CMAX) eset = 1;
                else m_cred++;
            end
            m_err  = m_err | eset;
            m_fv   = acc;
            if (acc) m_fo = fwd;
            m_lock = nlock;
            tick();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
